// File: rtl/byte_stripe_sched.sv
// -----------------------------------------------------------------------------
// byte_stripe_sched
//
// Two-lane striping scheduler. Words accepted from a ready/valid source are
// distributed strictly round-robin onto lane 0 and lane 1. Each lane owns a
// small first-word-fall-through FIFO with its own downstream handshake, so
// the two consumers drain independently.
//
// A full target lane stalls the input rather than letting the scheduler skip
// to the other lane. Strict alternation is what lets the unstriper rebuild
// the original word order, so it must never be broken.
//
// Parameters
//   DATA_WIDTH  width of data words and of each lane
//   DEPTH       entries per lane FIFO (power of two, >= 2)
//
// Ports
//   clk_2f      clock; all state updates on the rising edge
//   reset       asynchronous, active-high reset; discards all buffered words
//   valid_in    source word valid
//   data_in     source word
//   in_ready    block can accept data_in this cycle
//   realign     force the next accepted word onto lane 0
//   lane0/1     head of lane FIFO (all-zero when the lane is empty)
//   valid_0/1   lane holds a valid word
//   ready_0/1   lane consumer accepts the head word
//   selector    lane that receives the next accepted word
//   occ_0/1     lane FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module byte_stripe_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk_2f,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic                    in_ready,
  input  logic                    realign,
  output logic [DATA_WIDTH-1:0]   lane0,
  output logic                    valid_0,
  input  logic                    ready_0,
  output logic [DATA_WIDTH-1:0]   lane1,
  output logic                    valid_1,
  input  logic                    ready_1,
  output logic                    selector,
  output logic [$clog2(DEPTH):0]  occ_0,
  output logic [$clog2(DEPTH):0]  occ_1
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] FULL_COUNT = OW'(DEPTH);

  logic                  accept;
  logic [1:0]            push;
  logic [1:0]            pop;
  logic [1:0]            full;
  logic [1:0]            vld;
  logic [1:0]            rdy;
  logic [DATA_WIDTH-1:0] head [2];
  logic [OW-1:0]         occ  [2];

  assign rdy = {ready_1, ready_0};

  // in_ready depends only on registered occupancy and reset: a pop in the
  // same cycle does not free the slot early, which keeps ready_k off the
  // input handshake path.
  assign in_ready = !reset && !full[selector];
  assign accept   = valid_in && in_ready;
  assign push     = {accept && selector, accept && !selector};

  // ---------------------------------------------------------------------------
  // Lane selector. realign wins over the toggle; a word accepted on the same
  // edge still uses the pre-edge selector because push is decoded from the
  // current register value.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of the order the blocks are evaluated.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      selector <= 1'b0;
    end else if (realign) begin
      selector <= 1'b0;
    end else if (accept) begin
      selector <= ~selector;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-lane FWFT FIFO. Pointers wrap naturally because DEPTH is a power of
  // two; occupancy is kept in a separate counter so full and empty are never
  // ambiguous.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < 2; k++) begin : g_lane
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [OW-1:0]         count;
    logic [OW-1:0]         count_next;

    assign full[k] = (count == FULL_COUNT);
    assign vld[k]  = (count != '0);
    assign pop[k]  = vld[k] && rdy[k];

    // NOTE: the storage array has no reset; resetting the counter and
    // pointers is enough to discard its contents, and the head output is
    // gated to zero whenever the lane is empty.
    always_ff @(posedge clk_2f) begin
      if (push[k]) begin
        mem[wr_ptr] <= data_in;
      end
    end

    // NOTE: count_next gets its default before the case so no path through
    // this block leaves it unassigned (which would infer a latch).
    always_comb begin
      count_next = count;
      case ({push[k], pop[k]})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
    end

    always_ff @(posedge clk_2f or posedge reset) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[k]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[k])  rd_ptr <= rd_ptr + 1'b1;
        count <= count_next;
      end
    end

    assign head[k] = vld[k] ? mem[rd_ptr] : '0;
    assign occ[k]  = count;
  end

  assign lane0   = head[0];
  assign lane1   = head[1];
  assign valid_0 = vld[0];
  assign valid_1 = vld[1];
  assign occ_0   = occ[0];
  assign occ_1   = occ[1];

endmodule
